// File: rtl/sc_dispatch_pkg.sv
// Shared types and reply codes for the slow-control dispatcher.
// Imported by the dispatcher top and its port decoder.
package sc_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_NOPORT   = 32'hFFFF_FFFF;
  localparam logic [31:0] ERR_TIMEOUT  = 32'hFFFF_0001;
  localparam logic [31:0] RST_RPLY_ERR = ERR_NOPORT;

endpackage

// File: rtl/sc_port_decode.sv
// Combinational sc_port lookup against the packed port table.
// The lowest matching slave index wins.
module sc_port_decode
  import sc_dispatch_pkg::*;
#(
  parameter int NSLV = 5,
  parameter int IDX_W = 3,
  parameter logic [16*NSLV-1:0] PORTS = '0
) (
  input  logic [15:0]      port,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (PORTS[16*i +: 16] == port) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sc_dispatch_ctrl.sv
// Routes one sc frame to a single slave, guards it with a watchdog
// and returns a registered reply (or an error code) to the master.
module sc_dispatch_ctrl
  import sc_dispatch_pkg::*;
#(
  parameter int NSLV = 5,
  parameter logic [16*NSLV-1:0] PORTS =
    {16'h1798, 16'h1797, 16'h1978, 16'h1977, 16'h1877},
  parameter int TMO_W = 20,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       sc_port,
  input  logic              sc_frame,
  output logic              sc_ack,
  output logic [31:0]       sc_rply_data,
  output logic [31:0]       sc_rply_error,
  output logic [NSLV-1:0]   slv_frame,
  input  logic [NSLV-1:0]   slv_ack,
  input  logic [32*NSLV-1:0] slv_rply_data,
  input  logic [32*NSLV-1:0] slv_rply_error,
  output logic              stat_busy,
  output logic [15:0]       stat_trans_cnt,
  output logic [15:0]       stat_tmo_cnt
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  sel, sel_n, idx;
  logic              hit;
  logic [TMO_W-1:0]  cnt, cnt_n;
  logic [31:0]       data_n, err_n;
  logic [15:0]       trans_n, tmo_n;
  logic [NSLV-1:0]   frame_n;

  sc_port_decode #(
    .NSLV  (NSLV),
    .IDX_W (IDX_W),
    .PORTS (PORTS)
  ) u_decode (
    .port (sc_port),
    .hit  (hit),
    .idx  (idx)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    data_n  = sc_rply_data;
    err_n   = sc_rply_error;
    trans_n = stat_trans_cnt;
    tmo_n   = stat_tmo_cnt;
    unique case (state)
      IDLE: begin
        if (sc_frame) begin
          if (hit) begin
            sel_n   = idx;
            cnt_n   = '0;
            state_n = WAIT;
          end else begin
            data_n  = '0;
            err_n   = ERR_NOPORT;
            state_n = DONE;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt + 1'b1;
        // abort beats ack, ack beats watchdog
        if (!sc_frame) begin
          state_n = IDLE;
        end else if (slv_ack[sel]) begin
          data_n  = slv_rply_data[32*sel +: 32];
          err_n   = slv_rply_error[32*sel +: 32];
          trans_n = stat_trans_cnt + 1'b1;
          state_n = DONE;
        end else if (cnt == TMO_LAST) begin
          data_n  = '0;
          err_n   = ERR_TIMEOUT;
          tmo_n   = stat_tmo_cnt + 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!sc_frame) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    frame_n = '0;
    if (state_n == WAIT) frame_n[sel_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      sel            <= '0;
      cnt            <= '0;
      sc_ack         <= 1'b0;
      slv_frame      <= '0;
      sc_rply_data   <= '0;
      sc_rply_error  <= RST_RPLY_ERR;
      stat_busy      <= 1'b0;
      stat_trans_cnt <= '0;
      stat_tmo_cnt   <= '0;
    end else begin
      state          <= state_n;
      sel            <= sel_n;
      cnt            <= cnt_n;
      sc_ack         <= (state_n == DONE);
      slv_frame      <= frame_n;
      sc_rply_data   <= data_n;
      sc_rply_error  <= err_n;
      stat_busy      <= (state_n != IDLE);
      stat_trans_cnt <= trans_n;
      stat_tmo_cnt   <= tmo_n;
    end
  end

endmodule

// File: tb/tb_sc_dispatch_ctrl.sv
// Directed cycle vectors plus watchdog sequences for sc_dispatch_ctrl.
// Slave replies are fixed per slave; TIMEOUT is shortened to 8.
module tb_sc_dispatch_ctrl;

  localparam int NSLV = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic [15:0]       sc_port;
  logic              sc_frame;
  logic              sc_ack;
  logic [31:0]       sc_rply_data;
  logic [31:0]       sc_rply_error;
  logic [NSLV-1:0]   slv_frame;
  logic [NSLV-1:0]   slv_ack;
  logic [32*NSLV-1:0] slv_rply_data;
  logic [32*NSLV-1:0] slv_rply_error;
  logic              stat_busy;
  logic [15:0]       stat_trans_cnt;
  logic [15:0]       stat_tmo_cnt;

  int checks = 0;
  int errors = 0;

  sc_dispatch_ctrl #(
    .NSLV    (NSLV),
    .TMO_W   (20),
    .TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sc_port        (sc_port),
    .sc_frame       (sc_frame),
    .sc_ack         (sc_ack),
    .sc_rply_data   (sc_rply_data),
    .sc_rply_error  (sc_rply_error),
    .slv_frame      (slv_frame),
    .slv_ack        (slv_ack),
    .slv_rply_data  (slv_rply_data),
    .slv_rply_error (slv_rply_error),
    .stat_busy      (stat_busy),
    .stat_trans_cnt (stat_trans_cnt),
    .stat_tmo_cnt   (stat_tmo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        frame;
    logic [15:0] port;
    logic [4:0]  ack;
    logic        e_ack;
    logic [4:0]  e_frame;
    logic [31:0] e_data;
    logic [31:0] e_err;
    logic        e_busy;
    logic [15:0] e_trans;
    logic [15:0] e_tmo;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input vec_t v);
    chk("sc_ack", step, 32'(sc_ack), 32'(v.e_ack));
    chk("slv_frame", step, 32'(slv_frame), 32'(v.e_frame));
    chk("rply_data", step, sc_rply_data, v.e_data);
    chk("rply_error", step, sc_rply_error, v.e_err);
    chk("busy", step, 32'(stat_busy), 32'(v.e_busy));
    chk("trans_cnt", step, 32'(stat_trans_cnt), 32'(v.e_trans));
    chk("tmo_cnt", step, 32'(stat_tmo_cnt), 32'(v.e_tmo));
  endtask

  initial begin
    // reset and idle
    vecs[0]  = '{0,0,16'h0000,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd0,16'd0};
    vecs[1]  = '{1,0,16'h0000,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd0,16'd0};
    // port 1977 -> slave 1, ack 3 cycles after slv_frame
    vecs[2]  = '{1,1,16'h1977,5'h00, 0,5'h02,32'h0,32'hFFFFFFFF,1,16'd0,16'd0};
    vecs[3]  = '{1,1,16'h1977,5'h00, 0,5'h02,32'h0,32'hFFFFFFFF,1,16'd0,16'd0};
    vecs[4]  = '{1,1,16'h1977,5'h00, 0,5'h02,32'h0,32'hFFFFFFFF,1,16'd0,16'd0};
    vecs[5]  = '{1,1,16'h1977,5'h02, 1,5'h00,32'h12345678,32'h0,1,16'd1,16'd0};
    vecs[6]  = '{1,1,16'h1977,5'h00, 1,5'h00,32'h12345678,32'h0,1,16'd1,16'd0};
    vecs[7]  = '{1,0,16'h1977,5'h00, 0,5'h00,32'h12345678,32'h0,0,16'd1,16'd0};
    // unknown port
    vecs[8]  = '{1,1,16'h1234,5'h00, 1,5'h00,32'h0,32'hFFFFFFFF,1,16'd1,16'd0};
    vecs[9]  = '{1,0,16'h1234,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd1,16'd0};
    // abort in WAIT, then slave 4 with stale ack[1] and port change
    vecs[10] = '{1,1,16'h1977,5'h00, 0,5'h02,32'h0,32'hFFFFFFFF,1,16'd1,16'd0};
    vecs[11] = '{1,0,16'h1798,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd1,16'd0};
    vecs[12] = '{1,1,16'h1798,5'h02, 0,5'h10,32'h0,32'hFFFFFFFF,1,16'd1,16'd0};
    vecs[13] = '{1,1,16'h1977,5'h02, 0,5'h10,32'h0,32'hFFFFFFFF,1,16'd1,16'd0};
    vecs[14] = '{1,1,16'h1977,5'h10, 1,5'h00,32'h44444444,32'h4,1,16'd2,16'd0};
    vecs[15] = '{1,0,16'h1977,5'h00, 0,5'h00,32'h44444444,32'h4,0,16'd2,16'd0};
    // slave 0 transaction, then reset while in DONE
    vecs[16] = '{1,1,16'h1877,5'h00, 0,5'h01,32'h44444444,32'h4,1,16'd2,16'd0};
    vecs[17] = '{1,1,16'h1877,5'h01, 1,5'h00,32'h00000011,32'h1,1,16'd3,16'd0};
    vecs[18] = '{0,1,16'h1877,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd0,16'd0};
    vecs[19] = '{1,0,16'h1877,5'h00, 0,5'h00,32'h0,32'hFFFFFFFF,0,16'd0,16'd0};

    slv_rply_data  = {32'h44444444, 32'h33333333, 32'h22222222,
                      32'h12345678, 32'h00000011};
    slv_rply_error = {32'h4, 32'h3, 32'h2, 32'h0, 32'h1};
    rstn     = 1'b0;
    sc_frame = 1'b0;
    sc_port  = '0;
    slv_ack  = '0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rstn     = vecs[i].rstn;
      sc_frame = vecs[i].frame;
      sc_port  = vecs[i].port;
      slv_ack  = vecs[i].ack;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i]);
    end

    // watchdog: slave 0 never acks
    @(negedge clk);
    sc_frame = 1'b1;
    sc_port  = 16'h1877;
    slv_ack  = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("tmo_frame", 100 + i, 32'(slv_frame), 32'h1);
      chk("tmo_noack", 100 + i, 32'(sc_ack), 32'h0);
    end
    @(posedge clk);
    #1;
    chk("tmo_ack", 108, 32'(sc_ack), 32'h1);
    chk("tmo_frame_off", 108, 32'(slv_frame), 32'h0);
    chk("tmo_data", 108, sc_rply_data, 32'h0);
    chk("tmo_err", 108, sc_rply_error, 32'hFFFF0001);
    chk("tmo_cnt", 108, 32'(stat_tmo_cnt), 32'd1);
    chk("tmo_trans", 108, 32'(stat_trans_cnt), 32'd0);
    @(negedge clk);
    sc_frame = 1'b0;
    @(posedge clk);
    #1;
    chk("tmo_release", 109, 32'(sc_ack), 32'h0);

    // ack lands on the timeout edge: ack wins
    @(negedge clk);
    sc_frame = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("race_frame", 200 + i, 32'(slv_frame), 32'h1);
      if (i == 7) slv_ack = 5'h01;
    end
    @(posedge clk);
    #1;
    slv_ack = '0;
    chk("race_ack", 208, 32'(sc_ack), 32'h1);
    chk("race_data", 208, sc_rply_data, 32'h00000011);
    chk("race_err", 208, sc_rply_error, 32'h1);
    chk("race_tmo", 208, 32'(stat_tmo_cnt), 32'd1);
    chk("race_trans", 208, 32'(stat_trans_cnt), 32'd1);
    @(negedge clk);
    sc_frame = 1'b0;
    @(posedge clk);
    #1;
    chk("race_release", 209, 32'(sc_ack), 32'h0);
    chk("race_idle", 209, 32'(stat_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
